// File: rtl/ad_ip_jesd204_tpl_adc_deframer_v2.sv
// JESD204 transport-layer ADC deframer: lane beats -> per-channel formatted samples,
// two register stages, SOF re-alignment FSM and a saturating gap counter.

module ad_ip_jesd204_tpl_adc_deframer_v2_fmt #(
   parameter int RES = 14
) (
   input  logic [15:0] word_i,
   input  logic        en_i,
   input  logic        type_i,
   input  logic        sext_i,
   output logic [15:0] sample_o
);
   localparam logic [31:0] LOW_M = (32'd1 << RES) - 32'd1;
   localparam logic [15:0] EXT_M = ~LOW_M[15:0];

   logic [RES-1:0] raw;
   logic           unused_tail;

   // tail bits below the converter resolution carry no sample information
   assign unused_tail = ^word_i;

   always_comb begin
      raw = word_i[15 -: RES];
      if (en_i && !type_i) raw[RES-1] = ~raw[RES-1];
      sample_o = 16'(raw) | ((en_i && sext_i && raw[RES-1]) ? EXT_M : 16'h0000);
   end
endmodule

module ad_ip_jesd204_tpl_adc_deframer_v2 #(
   parameter int NUM_LANES            = 1,
   parameter int NUM_CHANNELS         = 1,
   parameter int OCTETS_PER_BEAT      = 4,
   parameter int CONVERTER_RESOLUTION = 14,
   localparam int SPC = NUM_LANES*OCTETS_PER_BEAT/(2*NUM_CHANNELS)
) (
   input  logic                                  link_clk,
   input  logic                                  link_resetn,
   input  logic                                  link_valid,
   output logic                                  link_ready,
   input  logic [OCTETS_PER_BEAT-1:0]            link_sof,
   input  logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0] link_data,
   input  logic [NUM_CHANNELS-1:0]               dfmt_enable,
   input  logic [NUM_CHANNELS-1:0]               dfmt_type,
   input  logic [NUM_CHANNELS-1:0]               dfmt_sign_extend,
   input  logic [NUM_CHANNELS-1:0]               ch_enable,
   input  logic                                  sync_arm,
   output logic                                  sync_armed,
   output logic [NUM_CHANNELS-1:0]               adc_valid,
   output logic [NUM_CHANNELS*SPC*16-1:0]        adc_data,
   output logic [15:0]                           valid_drop_count
);
   if (SPC < 1 || SPC*2*NUM_CHANNELS != NUM_LANES*OCTETS_PER_BEAT) begin : g_bad_spc
      $error("deframer: lanes*octets must split into an integer number of samples per channel");
   end

   typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_ARMED} state_e;

   state_e state_q, state_d;
   logic   accept, beat_ok, seen_q, unused_sof;
   logic [15:0] drop_q, drop_d;
   logic [NUM_CHANNELS-1:0][SPC-1:0][15:0] fmt_w, s1_d, s1_q, out_q;
   logic [NUM_CHANNELS-1:0]                vld_d;
   logic [1:0][NUM_CHANNELS-1:0]           vld_pipe_q;

   assign link_ready = (state_q != ST_RESET);
   assign sync_armed = (state_q == ST_ARMED);
   assign accept     = link_valid & link_ready;
   // the aligning SOF beat is itself the first beat delivered
   assign beat_ok    = accept & ((state_q == ST_RUN) | ((state_q == ST_ARMED) & link_sof[0]));
   assign unused_sof = ^link_sof[OCTETS_PER_BEAT-1:1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN:   if (sync_arm) state_d = ST_ARMED;
         ST_ARMED: if (accept && link_sof[0]) state_d = ST_RUN;
         default:  state_d = ST_RESET;
      endcase
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      for (genvar s = 0; s < SPC; s++) begin : g_smp
         localparam int W = s*NUM_CHANNELS + c;
         ad_ip_jesd204_tpl_adc_deframer_v2_fmt #(.RES(CONVERTER_RESOLUTION)) u_fmt (
            .word_i   ({link_data[16*W +: 8], link_data[16*W+8 +: 8]}),
            .en_i     (dfmt_enable[c]),
            .type_i   (dfmt_type[c]),
            .sext_i   (dfmt_sign_extend[c]),
            .sample_o (fmt_w[c][s])
         );
      end
      assign s1_d[c]  = (beat_ok && ch_enable[c]) ? fmt_w[c] : '0;
      assign vld_d[c] = beat_ok & ch_enable[c];
   end

   always_comb begin
      drop_d = drop_q;
      if (state_q == ST_RUN && !link_valid && seen_q && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn) begin
         state_q    <= ST_RESET;
         seen_q     <= 1'b0;
         drop_q     <= '0;
         vld_pipe_q <= '0;
         s1_q       <= '0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         seen_q     <= seen_q | accept;
         drop_q     <= drop_d;
         vld_pipe_q <= {vld_pipe_q[0], vld_d};
         s1_q       <= s1_d;
         out_q      <= s1_q;
      end
   end

   assign adc_valid        = vld_pipe_q[1];
   assign adc_data         = out_q;
   assign valid_drop_count = drop_q;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer_v2.sv
// Directed bench: narrow default instance plus a 4-lane/2-channel instance for the wide mapping.

module tb_ad_ip_jesd204_tpl_adc_deframer_v2;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, valid, sync_arm, den, dtyp, dsx, chen;
   logic [3:0]  sof;
   logic [31:0] data;
   logic        ready0, armed0;
   logic [0:0]  av0;
   logic [31:0] ad0;
   logic [15:0] dc0;

   logic         v1;
   logic [7:0]   sof1;
   logic [255:0] data1;
   logic         ready1, armed1;
   logic [1:0]   av1;
   logic [255:0] ad1;
   logic [15:0]  dc1;

   int n_cmp = 0;
   int n_bad = 0;

   ad_ip_jesd204_tpl_adc_deframer_v2 u0 (
      .link_clk(clk), .link_resetn(rstn), .link_valid(valid), .link_ready(ready0),
      .link_sof(sof), .link_data(data), .dfmt_enable(den), .dfmt_type(dtyp),
      .dfmt_sign_extend(dsx), .ch_enable(chen), .sync_arm(sync_arm), .sync_armed(armed0),
      .adc_valid(av0), .adc_data(ad0), .valid_drop_count(dc0)
   );

   ad_ip_jesd204_tpl_adc_deframer_v2 #(
      .NUM_LANES(4), .NUM_CHANNELS(2), .OCTETS_PER_BEAT(8), .CONVERTER_RESOLUTION(16)
   ) u1 (
      .link_clk(clk), .link_resetn(rstn), .link_valid(v1), .link_ready(ready1),
      .link_sof(sof1), .link_data(data1), .dfmt_enable(2'b00), .dfmt_type(2'b00),
      .dfmt_sign_extend(2'b00), .ch_enable(2'b11), .sync_arm(1'b0), .sync_armed(armed1),
      .adc_valid(av1), .adc_data(ad1), .valid_drop_count(dc1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; valid = 1'b0; sync_arm = 1'b0; sof = '0; data = '0;
      den = 1'b0; dtyp = 1'b0; dsx = 1'b0; chen = 1'b1; v1 = 1'b0; sof1 = '0; data1 = '0;
      #2;
      n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready0); end
      n_cmp++; if (armed0 !== 1'b0) begin n_bad++; $display("FAIL reset_armed: got %b want 0", armed0); end
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", av0); end
      n_cmp++; if (ad0 !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", ad0); end
      n_cmp++; if (dc0 !== 16'h0) begin n_bad++; $display("FAIL reset_drop: got %h want 0", dc0); end
      tick; tick;
      rstn = 1'b1;
      #1;
      n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL release_ready_early: got %b want 0", ready0); end
      tick;
      n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", ready0); end
   endtask

   task automatic test_basic;
      den = 1'b0; chen = 1'b1; data = 32'h78563412; valid = 1'b1;
      tick;
      valid = 1'b0;
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", av0); end
      tick;
      n_cmp++; if (av0 !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", av0); end
      n_cmp++; if (ad0 !== 32'h159E048D) begin n_bad++; $display("FAIL basic_data: got %h want 159e048d", ad0); end
   endtask

   task automatic test_dfmt;
      logic [2:0]  ctl [4];
      logic [31:0] din [4];
      logic [31:0] exp [4];
      ctl[0] = 3'b101; din[0] = 32'hFCFF0000; exp[0] = 32'h1FFFE000;
      ctl[1] = 3'b111; din[1] = 32'hFCFF0000; exp[1] = 32'hFFFF0000;
      ctl[2] = 3'b100; din[2] = 32'h00400080; exp[2] = 32'h30000000;
      ctl[3] = 3'b001; din[3] = 32'hFCFF0080; exp[3] = 32'h3FFF2000;
      for (int i = 0; i < 4; i++) begin
         {den, dtyp, dsx} = ctl[i];
         data = din[i]; valid = 1'b1;
         tick;
         valid = 1'b0;
         tick;
         n_cmp++; if (ad0 !== exp[i]) begin n_bad++; $display("FAIL dfmt_%0d: got %h want %h", i, ad0, exp[i]); end
      end
      den = 1'b0; dtyp = 1'b0; dsx = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [31:0] din [3];
      logic [31:0] exp [3];
      din[0] = 32'h78563412; exp[0] = 32'h159E048D;
      din[1] = 32'h00000000; exp[1] = 32'h00000000;
      din[2] = 32'hFFFFFFFF; exp[2] = 32'h3FFF3FFF;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin valid = 1'b1; data = din[i]; end
         else valid = 1'b0;
         tick;
         if (i >= 1) begin
            n_cmp++; if (av0 !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_%0d: got %b want 1", i-1, av0); end
            n_cmp++; if (ad0 !== exp[i-1]) begin n_bad++; $display("FAIL b2b_data_%0d: got %h want %h", i-1, ad0, exp[i-1]); end
         end
      end
      tick;
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid: got %b want 0", av0); end
      n_cmp++; if (ad0 !== 32'h0) begin n_bad++; $display("FAIL b2b_idle_data: got %h want 0", ad0); end
   endtask

   task automatic test_ch_disable;
      chen = 1'b0; data = 32'h78563412; valid = 1'b1;
      tick;
      valid = 1'b0;
      tick;
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL chdis_valid: got %b want 0", av0); end
      n_cmp++; if (ad0 !== 32'h0) begin n_bad++; $display("FAIL chdis_data: got %h want 0", ad0); end
      chen = 1'b1;
   endtask

   task automatic test_wide;
      logic [255:0] exp1;
      for (int w = 0; w < 16; w++) data1[16*w +: 16] = 16'(w) << 8;
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 8; s++) exp1[(c*8+s)*16 +: 16] = 16'(2*s + c);
      v1 = 1'b1;
      tick;
      v1 = 1'b0;
      tick;
      n_cmp++; if (av1 !== 2'b11) begin n_bad++; $display("FAIL wide_valid: got %b want 11", av1); end
      n_cmp++; if (ad1 !== exp1) begin n_bad++; $display("FAIL wide_data: got %h want %h", ad1, exp1); end
   endtask

   task automatic test_sync;
      int armed_cnt = 0;
      int stray = 0;
      sync_arm = 1'b1; valid = 1'b0;
      tick;
      sync_arm = 1'b0;
      if (armed0) armed_cnt++;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; sof = (i == 3) ? 4'b0001 : 4'b0000;
         data = (i == 3) ? 32'h78563412 : 32'hFFFFFFFF;
         tick;
         if (armed0) armed_cnt++;
         if (av0 !== 1'b0) stray++;
      end
      valid = 1'b0; sof = '0;
      n_cmp++; if (armed_cnt != 4) begin n_bad++; $display("FAIL sync_armed_cycles: got %0d want 4", armed_cnt); end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL sync_drop: got %0d valid beats want 0", stray); end
      tick;
      n_cmp++; if (av0 !== 1'b1) begin n_bad++; $display("FAIL sync_first_valid: got %b want 1", av0); end
      n_cmp++; if (ad0 !== 32'h159E048D) begin n_bad++; $display("FAIL sync_first_data: got %h want 159e048d", ad0); end
   endtask

   task automatic test_sync_collision;
      sync_arm = 1'b1; valid = 1'b1; sof = 4'b0001; data = 32'h78563412;
      tick;
      sync_arm = 1'b0; sof = 4'b0000; data = 32'h00000000;
      n_cmp++; if (armed0 !== 1'b1) begin n_bad++; $display("FAIL coll_armed: got %b want 1", armed0); end
      tick;
      n_cmp++; if (armed0 !== 1'b1) begin n_bad++; $display("FAIL coll_still_armed: got %b want 1", armed0); end
      n_cmp++; if (ad0 !== 32'h159E048D) begin n_bad++; $display("FAIL coll_run_beat: got %h want 159e048d", ad0); end
      sync_arm = 1'b1; sof = 4'b0001; data = 32'hFFFFFFFF;
      tick;
      sync_arm = 1'b0; valid = 1'b0; sof = '0;
      n_cmp++; if (armed0 !== 1'b0) begin n_bad++; $display("FAIL coll_aligned: got %b want 0", armed0); end
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL coll_dropped: got %b want 0", av0); end
      tick;
      n_cmp++; if (ad0 !== 32'h3FFF3FFF) begin n_bad++; $display("FAIL coll_sof_data: got %h want 3fff3fff", ad0); end
      n_cmp++; if (armed0 !== 1'b0) begin n_bad++; $display("FAIL coll_no_rearm: got %b want 0", armed0); end
   endtask

   task automatic test_reset_midstream;
      valid = 1'b1; data = 32'h78563412;
      tick; tick; tick;
      n_cmp++; if (av0 !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", av0); end
      rstn = 1'b0;
      #1;
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", av0); end
      n_cmp++; if (ad0 !== 32'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", ad0); end
      n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", ready0); end
      n_cmp++; if (dc0 !== 16'h0) begin n_bad++; $display("FAIL mid_drop: got %h want 0", dc0); end
      valid = 1'b0;
      tick;
      rstn = 1'b1;
      tick;
      n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready: got %b want 1", ready0); end
      tick;
      n_cmp++; if (av0 !== 1'b0) begin n_bad++; $display("FAIL mid_inflight: got %b want 0", av0); end
   endtask

   task automatic test_drop;
      tick; tick; tick;
      n_cmp++; if (dc0 !== 16'h0) begin n_bad++; $display("FAIL drop_before_beat: got %h want 0", dc0); end
      valid = 1'b1; data = 32'h12345678;
      tick;
      valid = 1'b0;
      repeat (5) tick;
      n_cmp++; if (dc0 !== 16'd5) begin n_bad++; $display("FAIL drop_five: got %0d want 5", dc0); end
      repeat (70000) tick;
      n_cmp++; if (dc0 !== 16'hFFFF) begin n_bad++; $display("FAIL drop_saturate: got %h want ffff", dc0); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_dfmt;
      test_back_to_back;
      test_ch_disable;
      test_wide;
      test_sync;
      test_sync_collision;
      test_reset_midstream;
      test_drop;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
